// File: rtl/rand_key_collector.sv
// Packs NUM_WORDS entropy words into a key register behind a valid/ack handshake
// and runs a repetition-count health test on the incoming stream.
module rand_key_collector #(
   parameter int NUM_WORDS = 8,
   parameter int REP_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [31:0]             entropy_data,
   input  logic                    entropy_valid,
   output logic                    entropy_ack,
   input  logic                    key_reload,
   output logic [32*NUM_WORDS-1:0] key,
   output logic                    key_loaded,
   output logic                    alarm
);

   localparam int KW  = 32 * NUM_WORDS;
   localparam int WCW = $clog2(NUM_WORDS + 1);
   localparam int RCW = $clog2(REP_LIMIT + 1);
   localparam logic [WCW-1:0] WC_FULL = WCW'(NUM_WORDS);
   localparam logic [RCW-1:0] RC_LIM  = RCW'(REP_LIMIT);

   typedef enum logic [2:0] {IDLE, COLLECT, ACK, LOADED, ALARM} state_t;

   state_t           state, state_nxt;
   logic [WCW-1:0]   word_cnt;
   logic [RCW-1:0]   rep_cnt;
   logic [31:0]      prev_word;
   logic [KW-1:0]    key_reg;
   logic [KW-1:0]    key_shift;
   logic             take_word;
   logic             clear_cnt;

   // Oldest word migrates toward the MSBs as new words enter at [31:0].
   generate
      if (NUM_WORDS == 1) begin : g_single
         assign key_shift = entropy_data;
      end else begin : g_multi
         assign key_shift = {key_reg[KW-33:0], entropy_data};
      end
   endgenerate

   assign take_word = (state == COLLECT) && enable && entropy_valid;
   assign clear_cnt = (state == IDLE)
                    || ((state == LOADED) && enable && key_reload)
                    || ((state == ALARM) && key_reload);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = COLLECT;
         COLLECT: begin
            if (!enable)            state_nxt = IDLE;
            else if (entropy_valid) state_nxt = ACK;
         end
         // Alarm takes priority so a repeat on the final word never loads.
         ACK: begin
            if (rep_cnt == RC_LIM)        state_nxt = ALARM;
            else if (word_cnt == WC_FULL) state_nxt = LOADED;
            else                          state_nxt = COLLECT;
         end
         LOADED: begin
            if (!enable)         state_nxt = IDLE;
            else if (key_reload) state_nxt = COLLECT;
         end
         ALARM:   if (key_reload) state_nxt = COLLECT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         word_cnt  <= '0;
         rep_cnt   <= '0;
         prev_word <= '0;
         key_reg   <= '0;
      end else begin
         state <= state_nxt;
         if (clear_cnt) begin
            word_cnt <= '0;
            rep_cnt  <= '0;
            key_reg  <= '0;
         end else if (take_word) begin
            key_reg   <= key_shift;
            word_cnt  <= word_cnt + WCW'(1);
            rep_cnt   <= ((rep_cnt != '0) && (entropy_data == prev_word))
                         ? rep_cnt + RCW'(1) : RCW'(1);
            prev_word <= entropy_data;
         end else if (state == ALARM) begin
            key_reg <= '0;
         end
      end
   end

   assign entropy_ack = (state == ACK);
   assign key_loaded  = (state == LOADED);
   assign alarm       = (state == ALARM);
   assign key         = key_loaded ? key_reg : '0;

endmodule

// File: tb/tb_rand_key_collector.sv
// Directed/randomized bench for rand_key_collector against a queue-based model
// of the collected words and the repetition health test.
module tb_rand_key_collector;

   localparam int NW = 8;
   localparam int RL = 4;
   localparam int KW = 32 * NW;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic [31:0]   entropy_data = '0;
   logic          entropy_valid = 1'b0;
   logic          entropy_ack;
   logic          key_reload = 1'b0;
   logic [KW-1:0] key;
   logic          key_loaded;
   logic          alarm;

   int checks = 0;
   int failures = 0;
   logic [31:0] words[$];

   rand_key_collector #(.NUM_WORDS(NW), .REP_LIMIT(RL)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .entropy_data(entropy_data), .entropy_valid(entropy_valid),
      .entropy_ack(entropy_ack), .key_reload(key_reload),
      .key(key), .key_loaded(key_loaded), .alarm(alarm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Key is the collected words in arrival order, first word most significant.
   function automatic logic [KW-1:0] model_key();
      logic [KW-1:0] k = '0;
      foreach (words[i]) k = (k << 32) | KW'(words[i]);
      return k;
   endfunction

   function automatic int run_len();
      int n = 0;
      for (int i = words.size() - 1; i >= 0; i--) begin
         if (words[i] == words[words.size() - 1]) n++;
         else break;
      end
      return n;
   endfunction

   function automatic logic [31:0] rnd_distinct(input logic [31:0] prev);
      logic [31:0] x;
      do x = $urandom; while (x == prev);
      return x;
   endfunction

   // Called just after a falling edge; returns just after a falling edge.
   task automatic send_word(input logic [31:0] d, input string tag);
      bit  seen = 0;
      bit  exp_alarm, exp_loaded;
      entropy_valid = 1'b1;
      entropy_data  = d;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (entropy_ack === 1'b1) seen = 1;
      end
      check({tag, "_ack_seen"}, KW'(seen), KW'(1));
      entropy_valid = 1'b0;
      if (seen) begin
         words.push_back(d);
         @(negedge clk);
         exp_alarm  = (run_len() >= RL);
         exp_loaded = !exp_alarm && (words.size() == NW);
         check({tag, "_ack_width"}, KW'(entropy_ack), KW'(0));
         check({tag, "_alarm"}, KW'(alarm), KW'(exp_alarm));
         check({tag, "_loaded"}, KW'(key_loaded), KW'(exp_loaded));
         check({tag, "_key"}, key, exp_loaded ? model_key() : '0);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable = 1'b0;
      entropy_valid = 1'b0;
      key_reload = 1'b0;
      words.delete();
      repeat (2) @(negedge clk);
      check("rst_ack", KW'(entropy_ack), KW'(0));
      check("rst_key", key, '0);
      check("rst_loaded", KW'(key_loaded), KW'(0));
      check("rst_alarm", KW'(alarm), KW'(0));
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] d;

      // Test 1: sequential words 1..8
      do_reset();
      enable = 1'b1;
      for (int i = 1; i <= NW; i++) send_word(32'(i), "t1");
      check("t1_key_const", key, 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);

      // Test 2: valid held continuously, ack must alternate
      do_reset();
      enable = 1'b1;
      @(negedge clk);
      d = $urandom;
      entropy_data = d;
      entropy_valid = 1'b1;
      for (int i = 1; i <= 2 * NW; i++) begin
         @(negedge clk);
         if (i < 2 * NW) check("t2_ack_toggle", KW'(entropy_ack), KW'(i % 2));
         check("t2_loaded", KW'(key_loaded), KW'(i == 2 * NW));
         if (entropy_ack === 1'b1) begin
            words.push_back(entropy_data);
            d = rnd_distinct(entropy_data);
            entropy_data = d;
         end
      end
      entropy_valid = 1'b0;
      check("t2_key", key, model_key());

      // Test 3: four identical words raise a sticky alarm
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < RL; i++) send_word(32'hA5A5A5A5, "t3");
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("t3_alarm_sticky", KW'(alarm), KW'(1));
      check("t3_alarm_key", key, '0);
      enable = 1'b1;
      key_reload = 1'b1;
      @(negedge clk);
      key_reload = 1'b0;
      check("t3_reload_alarm", KW'(alarm), KW'(0));
      words.delete();
      // repetition landing on the final word must alarm, not load
      d = $urandom;
      for (int i = 0; i < NW - RL; i++) begin
         d = rnd_distinct(d);
         send_word(d, "t3b");
      end
      d = rnd_distinct(d);
      for (int i = 0; i < RL; i++) send_word(d, "t3c");
      check("t3c_final_alarm", KW'(alarm), KW'(1));

      // Test 4: REP_LIMIT-1 repeats are tolerated
      do_reset();
      enable = 1'b1;
      for (int i = 0; i < RL - 1; i++) send_word(32'hA5A5A5A5, "t4");
      send_word(32'h5A5A5A5A, "t4");
      d = 32'h5A5A5A5A;
      for (int i = 0; i < NW - RL; i++) begin
         d = rnd_distinct(d);
         send_word(d, "t4");
      end
      check("t4_loaded", KW'(key_loaded), KW'(1));

      // Test 5: dropping enable restarts the count
      do_reset();
      enable = 1'b1;
      d = 32'h1;
      for (int i = 0; i < 3; i++) begin
         d = rnd_distinct(d);
         send_word(d, "t5a");
      end
      enable = 1'b0;
      entropy_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t5_idle_ack", KW'(entropy_ack), KW'(0));
      end
      entropy_valid = 1'b0;
      words.delete();
      enable = 1'b1;
      for (int i = 0; i < NW; i++) begin
         d = rnd_distinct(d);
         send_word(d, "t5b");
      end

      // Test 6: asynchronous reset in LOADED, then enable=0 beats key_reload
      check("t6_pre_loaded", KW'(key_loaded), KW'(1));
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_loaded", KW'(key_loaded), KW'(0));
      check("t6_async_key", key, '0);
      check("t6_async_alarm", KW'(alarm), KW'(0));
      @(negedge clk);
      reset_n = 1'b1;
      words.delete();
      enable = 1'b1;
      for (int i = 0; i < NW; i++) begin
         d = rnd_distinct(d);
         send_word(d, "t6b");
      end
      enable = 1'b0;
      key_reload = 1'b1;
      @(negedge clk);
      key_reload = 1'b0;
      check("t6_en_wins_loaded", KW'(key_loaded), KW'(0));
      check("t6_en_wins_key", key, '0);
      check("t6_en_wins_alarm", KW'(alarm), KW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
